// File: rtl/hci_tcdm_bank_responder.sv
// Single-bank TCDM responder: byte-enabled writes, 1-cycle reads, and an
// atomic test-and-set that returns the old word and then writes all-ones
// back to the same address in a dedicated one-cycle write-back state.
module hci_tcdm_bank_responder #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned IW = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   id_i,
  input  logic            ts_set_i,
  output logic            gnt_o,
  output logic            r_valid_o,
  output logic [DW-1:0]   r_data_o,
  output logic [IW-1:0]   r_id_o
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WB = 1'b1
  } state_e;

  state_e          state;
  logic [AW-1:0]   ts_addr;
  logic [DW-1:0]   mem [DEPTH];

  logic accept;
  logic ts_start;

  // The bank is busy only while the test-and-set write-back owns the array,
  // so the grant depends on the state register alone (no req_i -> gnt_o path).
  assign gnt_o    = (state == IDLE);
  assign accept   = req_i & gnt_o;
  // A test-and-set only counts on a granted read; on a write it is ignored.
  assign ts_start = accept & wen_i & ts_set_i;

  // FSM: a granted test-and-set read arms exactly one write-back cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ts_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ts_start) begin
            state   <= TS_WB;
            ts_addr <= add_i;
          end
        end
        TS_WB:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: write-back of all-ones has priority; otherwise granted writes
  // update only the enabled bytes. An async reset during TS_WB forces the
  // state to IDLE before the next edge, which drops the pending write-back.
  // NOTE: the array has no reset branch on purpose; resetting thousands of
  // words would turn a RAM into flops and contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (state == TS_WB) begin
      mem[ts_addr] <= '1;
    end else if (accept && !wen_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) begin
          mem[add_i][8*k +: 8] <= data_i[8*k +: 8];
        end
      end
    end
  end

  // Response: one registered pulse per grant; data/id hold when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_id_o    <= '0;
    end else begin
      r_valid_o <= accept;
      if (accept) begin
        r_id_o   <= id_i;
        r_data_o <= wen_i ? mem[add_i] : '0;
      end
    end
  end

endmodule
